// File: rtl/mymultiplier_pkg.sv
// Shared constants for the MYMULTIPLIER AXI4-Lite responder: register word
// indices, response code, STATUS bit positions, multiplier FSM encoding and a
// byte-strobe merge helper.
package mymultiplier_pkg;

  localparam logic [2:0] REG_OPA      = 3'd0;
  localparam logic [2:0] REG_OPB      = 3'd1;
  localparam logic [2:0] REG_SCRATCH0 = 3'd2;
  localparam logic [2:0] REG_SCRATCH1 = 3'd3;
  localparam logic [2:0] REG_PROD_LO  = 3'd4;
  localparam logic [2:0] REG_PROD_HI  = 3'd5;
  localparam logic [2:0] REG_STATUS   = 3'd6;
  localparam logic [2:0] REG_RSVD     = 3'd7;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mult_state_e;

  // Replace only the bytes whose strobe bit is set.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mymultiplier_axil_slave_if.sv
// AXI4-Lite link between the master BFM / interconnect and the responder.
//
// Handshake rule for every channel: a transfer happens on the rising clock
// edge where both VALID and READY are high. A source holds VALID and its
// payload stable until that edge; READY may depend on VALID.
interface mymultiplier_axil_slave_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/mymultiplier_seq_mult.sv
// Iterative 32x32 unsigned shift-add multiplier. A start pulse latches the
// operands; 32 add/shift iterations follow, and the product register and a
// one-cycle done pulse update on the 33rd edge after start. A start during a
// run discards that run silently.
module mymultiplier_seq_mult
  import mymultiplier_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done_pulse,
  output logic [63:0] product,
  output mult_state_e state_o
);

  mult_state_e state_q;
  logic [63:0] mcand_q;
  logic [32:0] mplier_q;   // multiplier bits with a sentinel 1 above them
  logic [63:0] acc_q;
  logic [63:0] product_q;
  logic        done_pulse_q;

  // FSM and datapath: the sentinel reaching bit 0 marks all 32 bits consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mcand_q      <= '0;
      mplier_q     <= '0;
      acc_q        <= '0;
      product_q    <= '0;
      done_pulse_q <= 1'b0;
    end else begin
      done_pulse_q <= 1'b0;
      if (start) begin
        state_q  <= ST_RUN;
        mcand_q  <= {32'd0, a};
        mplier_q <= {1'b1, b};
        acc_q    <= '0;
      end else if (state_q == ST_RUN) begin
        if (mplier_q == 33'd1) begin
          product_q    <= acc_q;
          done_pulse_q <= 1'b1;
          state_q      <= ST_IDLE;
        end else begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
        end
      end
    end
  end

  assign busy       = (state_q == ST_RUN);
  assign done_pulse = done_pulse_q;
  assign product    = product_q;
  assign state_o    = state_q;

endmodule

// File: rtl/mymultiplier_axil_slave.sv
// AXI4-Lite responder for MYMULTIPLIER: write/read handshakes, the operand
// and scratch register file, STATUS tracking and the registered read mux.
module mymultiplier_axil_slave
  import mymultiplier_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                      S_AXI_ACLK,
  input  logic                      S_AXI_ARESETN,
  mymultiplier_axil_slave_if.slave  s_axi,
  output logic                      mult_done_irq
);

  logic                          awready_q;
  logic                          bvalid_q;
  logic                          arready_q;
  logic                          rvalid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] opa_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] opb_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] scratch0_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] scratch1_q;
  logic                          done_q;

  logic                          wr_hs;
  logic                          rd_hs;
  logic [2:0]                    wr_idx;
  logic [2:0]                    rd_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] opb_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] status_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_word_d;

  logic                          mult_start;
  logic                          mult_busy;
  logic                          mult_done_pulse;
  logic [63:0]                   mult_product;
  mult_state_e                   mult_state;
  logic                          unused_ok;

  assign wr_idx = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_idx = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_hs  = awready_q && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID;
  assign rd_hs  = arready_q && s_axi.S_AXI_ARVALID;

  // OPB as it will read after this commit; the engine starts from this value.
  assign opb_d      = apply_wstrb(opb_q, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
  assign mult_start = wr_hs && (wr_idx == REG_OPB);

  assign unused_ok = &{1'b0, s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                       s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0], mult_state};

  mymultiplier_seq_mult u_mult (
    .clk        (S_AXI_ACLK),
    .rst_n      (S_AXI_ARESETN),
    .start      (mult_start),
    .a          (opa_q),
    .b          (opb_d),
    .busy       (mult_busy),
    .done_pulse (mult_done_pulse),
    .product    (mult_product),
    .state_o    (mult_state)
  );

  // Write channel: AW and W accepted together, one outstanding response.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      awready_q <= !awready_q && !bvalid_q && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID;
      if (wr_hs) bvalid_q <= 1'b1;
      else if (bvalid_q && s_axi.S_AXI_BREADY) bvalid_q <= 1'b0;
    end
  end

  // Read channel: data captured at the address handshake, held until RREADY.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      arready_q <= !arready_q && !rvalid_q && s_axi.S_AXI_ARVALID;
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_word_d;
      end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Register file commits and the sticky done flag.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      opa_q      <= '0;
      opb_q      <= '0;
      scratch0_q <= '0;
      scratch1_q <= '0;
      done_q     <= 1'b0;
    end else begin
      if (wr_hs) begin
        case (wr_idx)
          REG_OPA:      opa_q      <= apply_wstrb(opa_q, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
          REG_OPB:      opb_q      <= opb_d;
          REG_SCRATCH0: scratch0_q <= apply_wstrb(scratch0_q, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
          REG_SCRATCH1: scratch1_q <= apply_wstrb(scratch1_q, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
          default: ;
        endcase
      end
      if (mult_start) done_q <= 1'b0;
      else if (mult_done_pulse) done_q <= 1'b1;
    end
  end

  // STATUS word; done shows in the completion cycle itself via the pulse.
  always_comb begin
    status_d = '0;
    status_d[STATUS_BUSY_BIT] = mult_busy;
    status_d[STATUS_DONE_BIT] = done_q | mult_done_pulse;
  end

  // Read mux sampled at the AR handshake edge (pre-write values).
  always_comb begin
    rd_word_d = '0;
    case (rd_idx)
      REG_OPA:      rd_word_d = opa_q;
      REG_OPB:      rd_word_d = opb_q;
      REG_SCRATCH0: rd_word_d = scratch0_q;
      REG_SCRATCH1: rd_word_d = scratch1_q;
      REG_PROD_LO:  rd_word_d = mult_product[31:0];
      REG_PROD_HI:  rd_word_d = mult_product[63:32];
      REG_STATUS:   rd_word_d = status_d;
      REG_RSVD:     rd_word_d = '0;
      default:      rd_word_d = '0;
    endcase
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = awready_q;
  assign s_axi.S_AXI_BRESP   = RESP_OKAY;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = RESP_OKAY;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign mult_done_irq       = mult_done_pulse;

endmodule

// File: tb/tb_mymultiplier_axil_slave.sv
// Self-checking bench for mymultiplier_axil_slave: directed cases with literal
// expectations, a randomized register/multiply mix, and a per-cycle monitor
// comparing the irq and responses against a behavioural register-map model.
`timescale 1ns/1ps
module tb_mymultiplier_axil_slave;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int unsigned cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mymultiplier_axil_slave_if bus ();
  logic irq;

  mymultiplier_axil_slave dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .s_axi         (bus),
    .mult_done_irq (irq)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // Behavioural model of the register map
  logic [31:0] m_reg [4];
  logic [63:0] m_prod;
  logic        m_running;
  logic        m_done;
  logic [31:0] run_a, run_b;
  int unsigned run_end;
  int unsigned irq_count = 0;
  int unsigned last_irq_cyc = 0;
  int unsigned last_commit_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  function automatic logic [31:0] model_read(input int idx);
    case (idx)
      0, 1, 2, 3: return m_reg[idx];
      4:          return m_prod[31:0];
      5:          return m_prod[63:32];
      6:          return {30'd0, m_done, m_running};
      default:    return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = '0;
    m_prod = '0; m_running = 1'b0; m_done = 1'b0;
    run_a = '0; run_b = '0; run_end = 0;
  endtask

  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    if (idx < 4) m_reg[idx] = merge(m_reg[idx], d, s);
    if (idx == 1) begin
      run_a = m_reg[0];
      run_b = m_reg[1];
      run_end = cyc + 33;
      m_running = 1'b1;
      m_done = 1'b0;
    end
  endtask

  // ---------------- per-cycle compare process ----------------
  always @(negedge clk) begin
    logic exp_irq;
    exp_irq = 1'b0;
    if (rst_n && m_running && cyc == run_end) begin
      m_prod = {32'd0, run_a} * {32'd0, run_b};
      m_running = 1'b0;
      m_done = 1'b1;
      exp_irq = 1'b1;
    end
    chk("irq", irq, exp_irq);
    if (irq) begin
      irq_count++;
      last_irq_cyc = cyc;
    end
    if (bus.S_AXI_BVALID) chk("bresp", bus.S_AXI_BRESP, 2'b00);
    if (bus.S_AXI_RVALID) chk("rresp", bus.S_AXI_RRESP, 2'b00);
  end

  // ---------------- driver tasks ----------------
  task automatic aw_w_phase(input int idx, input logic [31:0] d, input logic [3:0] s);
    int t;
    bus.S_AXI_AWADDR  = 5'(idx << 2);
    bus.S_AXI_WDATA   = d;
    bus.S_AXI_WSTRB   = s;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    t = 0;
    do begin @(negedge clk); #1; t++; end while (!bus.S_AXI_AWREADY && t < 60);
    if (!bus.S_AXI_AWREADY) begin
      chk("aw_timeout", 1'b0, 1'b1);
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID  = 1'b0;
      return;
    end
    chk("wready_with_awready", bus.S_AXI_WREADY, 1'b1);
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    last_commit_cyc = cyc;
    model_write(idx, d, s);
  endtask

  task automatic b_phase(input int hold);
    int t;
    t = 0;
    while (!bus.S_AXI_BVALID && t < 60) begin @(negedge clk); #1; t++; end
    if (!bus.S_AXI_BVALID) begin
      chk("b_timeout", 1'b0, 1'b1);
      return;
    end
    repeat (hold) begin
      @(negedge clk); #1;
      chk("bvalid_hold", bus.S_AXI_BVALID, 1'b1);
    end
    bus.S_AXI_BREADY = 1'b1;
    @(posedge clk); #1;
    bus.S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_write(input int idx, input logic [31:0] d, input logic [3:0] s, input int hold);
    aw_w_phase(idx, d, s);
    b_phase(hold);
  endtask

  task automatic axi_read(input int idx, input int hold, output logic [31:0] data);
    int t;
    logic [31:0] exp;
    data = '0;
    bus.S_AXI_ARADDR  = 5'(idx << 2);
    bus.S_AXI_ARVALID = 1'b1;
    t = 0;
    do begin @(negedge clk); #1; t++; end while (!bus.S_AXI_ARREADY && t < 60);
    if (!bus.S_AXI_ARREADY) begin
      chk("ar_timeout", 1'b0, 1'b1);
      bus.S_AXI_ARVALID = 1'b0;
      return;
    end
    exp_q.push_back(model_read(idx));   // value before the handshake edge
    @(posedge clk); #1;
    bus.S_AXI_ARVALID = 1'b0;
    t = 0;
    while (!bus.S_AXI_RVALID && t < 60) begin @(negedge clk); #1; t++; end
    if (!bus.S_AXI_RVALID) begin
      chk("r_timeout", 1'b0, 1'b1);
      void'(exp_q.pop_front());
      return;
    end
    data = bus.S_AXI_RDATA;
    repeat (hold) begin
      @(negedge clk); #1;
      chk("rvalid_hold", bus.S_AXI_RVALID, 1'b1);
      chk("rdata_stable", bus.S_AXI_RDATA, data);
    end
    bus.S_AXI_RREADY = 1'b1;
    @(posedge clk); #1;
    bus.S_AXI_RREADY = 1'b0;
    exp = exp_q.pop_front();
    chk($sformatf("rdata_slot%0d", idx), data, exp);
  endtask

  task automatic check_outputs_zero(input string name);
    chk(name, {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.S_AXI_BRESP,
               bus.S_AXI_ARREADY, bus.S_AXI_RVALID, bus.S_AXI_RRESP, bus.S_AXI_RDATA, irq}, '0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rd;
    logic [31:0] wvals [4];
    int unsigned irq_before;
    int unsigned c1;

    wvals[0] = 32'h0101FFFF; wvals[1] = 32'hABCD0001;
    wvals[2] = 32'hDEAD0011; wvals[3] = 32'hBEEF0011;

    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    model_reset();

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_outputs_zero("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Slots 0..3 write/readback
    for (int i = 0; i < 4; i++) axi_write(i, wvals[i], 4'hF, 0);
    repeat (40) @(negedge clk);   // slot 1 write started a multiply
    for (int i = 0; i < 4; i++) begin
      axi_read(i, 0, rd);
      chk($sformatf("readback_slot%0d", i), rd, wvals[i]);
    end

    // 3 x 5
    axi_write(0, 32'd3, 4'hF, 0);
    axi_write(1, 32'd5, 4'hF, 0);
    c1 = last_commit_cyc;
    axi_read(6, 0, rd);
    chk("status_busy", rd, 32'h1);
    repeat (40) @(negedge clk);
    chk("irq_latency_3x5", last_irq_cyc - c1, 33);
    axi_read(4, 0, rd); chk("prod_lo_3x5", rd, 32'h0000000F);
    axi_read(5, 0, rd); chk("prod_hi_3x5", rd, 32'h0);
    axi_read(6, 0, rd); chk("status_done", rd, 32'h2);

    // Max operands
    axi_write(0, 32'hFFFFFFFF, 4'hF, 0);
    axi_write(1, 32'hFFFFFFFF, 4'hF, 0);
    repeat (40) @(negedge clk);
    axi_read(5, 0, rd); chk("prod_hi_max", rd, 32'hFFFFFFFE);
    axi_read(4, 0, rd); chk("prod_lo_max", rd, 32'h00000001);

    // OPA rewrite mid-run has no effect on the current run
    axi_write(0, 32'd6, 4'hF, 0);
    axi_write(1, 32'd7, 4'hF, 0);
    axi_write(0, 32'd100, 4'hF, 0);
    repeat (40) @(negedge clk);
    axi_read(4, 0, rd); chk("prod_lo_opa_midrun", rd, 32'd42);

    // Restart with OPB rewrite mid-run
    axi_write(0, 32'd3, 4'hF, 0);
    axi_write(1, 32'd7, 4'hF, 0);
    c1 = last_commit_cyc;
    irq_before = irq_count;
    while (cyc < c1 + 6) @(negedge clk);
    axi_write(0, 32'h80000000, 4'hF, 0);
    axi_write(1, 32'd2, 4'hF, 0);
    c1 = last_commit_cyc;
    repeat (45) @(negedge clk);
    chk("restart_single_irq", irq_count - irq_before, 1);
    chk("restart_irq_latency", last_irq_cyc - c1, 33);
    axi_read(5, 0, rd); chk("prod_hi_restart", rd, 32'h1);
    axi_read(4, 0, rd); chk("prod_lo_restart", rd, 32'h0);

    // Byte strobes and read-only slot
    axi_write(2, 32'h0, 4'hF, 0);
    axi_write(2, 32'h12345678, 4'b0010, 0);
    axi_read(2, 0, rd); chk("wstrb_byte1", rd, 32'h00005600);
    axi_write(4, 32'hFFFFFFFF, 4'hF, 0);
    axi_read(4, 0, rd); chk("prod_lo_ro", rd, 32'h0);

    // Read and write of the same slot on the same edge
    axi_write(3, 32'h11112222, 4'hF, 0);
    fork
      axi_write(3, 32'h33334444, 4'hF, 0);
      begin logic [31:0] r2; axi_read(3, 0, r2); chk("same_edge_pre_write", r2, 32'h11112222); end
    join
    axi_read(3, 0, rd); chk("same_edge_after", rd, 32'h33334444);

    // Back-pressure on B and R, second write held off
    aw_w_phase(2, 32'hCAFE0001, 4'hF);
    bus.S_AXI_AWADDR = 5'(3 << 2); bus.S_AXI_WDATA = 32'h0BAD0002; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    repeat (5) begin
      @(negedge clk); #1;
      chk("bvalid_backpressure", bus.S_AXI_BVALID, 1'b1);
      chk("aw_blocked", bus.S_AXI_AWREADY, 1'b0);
    end
    b_phase(0);
    axi_write(3, 32'h0BAD0002, 4'hF, 0);
    axi_read(2, 5, rd); chk("r_backpressure_data", rd, 32'hCAFE0001);
    axi_read(3, 0, rd); chk("second_write_data", rd, 32'h0BAD0002);

    // Randomized mix
    for (int n = 0; n < 150; n++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        axi_write($urandom_range(0, 7), $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
      end else if (op <= 7) begin
        axi_read($urandom_range(0, 7), $urandom_range(0, 2), rd);
      end else begin
        axi_write(0, $urandom, 4'hF, 0);
        axi_write(1, $urandom, 4'hF, 0);
      end
    end
    repeat (40) @(negedge clk);
    for (int i = 0; i < 8; i++) axi_read(i, 0, rd);

    // Asynchronous reset during a run
    axi_write(0, 32'h1234, 4'hF, 0);
    axi_write(1, 32'h5678, 4'hF, 0);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async_reset_outputs");
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    axi_read(6, 0, rd); chk("status_after_reset", rd, 32'h0);
    axi_read(4, 0, rd); chk("prod_lo_after_reset", rd, 32'h0);
    axi_read(0, 0, rd); chk("opa_after_reset", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mymultiplier_axil_slave.md
Name: mymultiplier_axil_slave

Overview:
AXI4-Lite responder (slave) for the MYMULTIPLIER peripheral. It is the subordinate end of the link driven by the AXI4-Lite master BFM.
- It decodes register writes and reads.
- It holds two 32-bit operands and two scratch registers.
- It runs an iterative 32x32 unsigned shift-add multiply, producing a 64-bit product readable over the bus.
- It sits directly behind the interconnect in the MYMULTIPLIER IP top level.

Parameters:
C_S_AXI_DATA_WIDTH, 32, bus data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 5, byte address width; bits [4:2] select one of 8 word slots.

Ports:
S_AXI_ACLK  in  1  single clock, rising edge
S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response, always OKAY (2'b00)
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response, always OKAY
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
mult_done_irq  out  1  one-cycle pulse on multiply completion

Behaviour:
- Reset (S_AXI_ARESETN low, asynchronous): all outputs 0. All registers 0. Multiplier idle, status = 0.
- Reset mid-multiply: abort immediately; product registers and status clear.
- Register map (word index = addr[4:2]):
  - 0 OPA, RW
  - 1 OPB, RW; a write commit starts a multiply
  - 2 SCRATCH0, RW
  - 3 SCRATCH1, RW
  - 4 PROD_LO, RO
  - 5 PROD_HI, RO
  - 6 STATUS, RO: bit0 busy, bit1 done (sticky), others 0
  - 7 reserved, reads 0
- Writes to RO or reserved slots: accepted with OKAY response, no effect.
- WSTRB: applies per byte to RW slots.
- Write channel:
  - AWREADY and WREADY assert together for one cycle, only when AWVALID && WVALID && !BVALID.
  - Address and data are captured and committed at that edge.
  - BVALID rises the next cycle and holds until BREADY.
  - No new write is accepted while BVALID is high.
  - A master presenting only AW or only W waits; nothing is captured.
- Read channel:
  - ARREADY pulses one cycle when ARVALID && !RVALID.
  - RDATA is registered at that edge; RVALID is high the next cycle and holds, with RDATA stable, until RREADY.
  - Read and write channels are independent.
  - A read and a write to the same slot handshaking on the same edge: the read returns the pre-write value.
- Multiplier FSM:
  - States: IDLE, RUN.
  - Start: on OPB commit edge N, the engine latches OPA and the new OPB and enters RUN at N+1, with busy=1 and done=0.
  - RUN: 32 iterations, one per cycle, each a conditional add of the shifted multiplicand plus a shift, using a 32-bit counter-free shift register or a 5-bit counter.
  - Completion: at edge N+33, PROD_LO/PROD_HI update atomically, busy=0, done=1, mult_done_irq pulses one cycle, and the FSM returns to IDLE.
  - PROD registers hold their previous value throughout RUN.
  - OPB written during RUN: restart from the new operands at the commit edge; no completion pulse for the aborted run.
  - OPA written during RUN: does not affect the current run, which uses the latched value.
  - Done clears only on the next start or on reset.
- Arithmetic: unsigned; the full 64-bit result is kept, no truncation.

Decomposition:
- Package mymultiplier_pkg holds:
  - register word-index constants (OPA..RSVD)
  - RESP_OKAY
  - STATUS bit positions
  - FSM state encoding
- One sub-module, mymultiplier_seq_mult. It takes clk, rst_n, start, a[31:0], b[31:0] and produces busy, done_pulse, product[63:0]. It contains the IDLE/RUN FSM and the shift-add datapath.
- The top module keeps the AXI handshake, register file and read mux.

Test Plan:
- Sequential write then read of slots 0..3 with 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 -> each BRESP/RRESP OKAY, each readback equal to the written value.
- OPA=3, OPB=5 -> STATUS=0x1 during run; mult_done_irq fires 33 cycles after the OPB commit; PROD_LO=0x0000000F, PROD_HI=0, STATUS=0x2.
- OPA=0xFFFFFFFF, OPB=0xFFFFFFFF -> PROD_HI=0xFFFFFFFE, PROD_LO=0x00000001.
- Multiply in flight, rewrite OPB=2 with OPA=0x80000000 at cycle 10 of the run -> a single irq 33 cycles after the second commit; PROD_HI=1, PROD_LO=0.
- Write slot 2 with WSTRB=4'b0010, data 0x12345678, over prior value 0 -> reads 0x00005600. Write 0xFFFFFFFF to PROD_LO -> OKAY, value unchanged.
- Back-pressure: BREADY and RREADY held low for 5 cycles -> BVALID/RVALID held high and RDATA stable; a second AW+W offered is not accepted until B completes. Assert ARESETN low during RUN -> all outputs 0 asynchronously and STATUS reads 0 after reset release.
